fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives the instruction-memory read handshake and
//  presents {instruction, incremented_pc, inst_stall, inst_mis_align} to the IF/ID pipe
//  register. Handles multi-cycle memory, branch/jump/RTI redirect from EX, decode stall and
//  HALT. One instruction per cycle on a single-cycle memory hit.
// PARAMETERS
//  RESET_PC  16'h0000  PC value loaded on reset
//  NOP_INST  16'h0800  encoding driven on instruction when no valid fetch is presented
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  pc_redirect     in   1   EX redirect (taken branch/jump/RTI/exception); wins over all but rst
//  redirect_pc     in   16  redirect target, valid with pc_redirect
//  stall_fetch     in   1   decode/hazard stall: hold PC, keep fetched word
//  halt_in         in   1   HALT decoded: stop fetching permanently (until rst)
//  imem_rd         out  1   memory read request
//  imem_addr       out  16  memory address (always current PC)
//  imem_rdata      in   16  memory data, valid with imem_done
//  imem_done       in   1   read complete this cycle (may be same cycle as request)
//  instruction     out  16  fetched word, NOP_INST when not valid
//  incremented_pc  out  16  PC+2 of the presented fetch
//  inst_stall      out  1   1 = no valid fetch this cycle (memory pending/draining)
//  inst_mis_align  out  1   PC[0]=1; instruction = NOP_INST
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=FETCH, buf_valid=0, drain target cleared.
//   While rst high: imem_rd=0, instruction=NOP_INST, inst_stall=0, inst_mis_align=0,
//   incremented_pc=RESET_PC+2. Reset mid-read abandons the outstanding access.
//  incremented_pc = pc + 2, 16-bit modulo (16'hFFFE -> 16'h0000).
//  States: FETCH, WAIT, DRAIN, HALTED. Priority per cycle: rst > redirect > halt > stall.
//  FETCH: if buf_valid: imem_rd=0, instruction=buf; else imem_rd=1, imem_addr=pc.
//   - pc[0]=1: imem_rd=0, instruction=NOP_INST, inst_mis_align=1, pc held until redirect.
//   - done & !stall_fetch: instruction=imem_rdata, inst_stall=0, pc<=pc+2 next edge.
//   - done & stall_fetch: instruction=imem_rdata, buf<=imem_rdata, buf_valid<=1, pc held.
//   - buf_valid & !stall_fetch: present buf, buf_valid<=0, pc<=pc+2.
//   - !done (no buf): inst_stall=1, instruction=NOP_INST, -> WAIT.
//  WAIT: imem_rd held 1, imem_addr stable; inst_stall=1 until done; on done behave as FETCH
//   hit (incl. stall capture) and return to FETCH.
//  Redirect: pc<=redirect_pc, buf_valid<=0, presented word forced NOP_INST, inst_stall=0.
//   In FETCH, or WAIT with done same cycle: load target, ->FETCH next cycle.
//   In WAIT without done: latch target, ->DRAIN; DRAIN holds imem_rd/addr until done,
//   discards data, then pc<=target, ->FETCH. Later redirect in DRAIN overwrites target.
//  Halt: halt_in in FETCH -> HALTED; in WAIT -> DRAIN (discard), then HALTED.
//   Redirect same cycle as halt: redirect taken, halt ignored (wrong path).
//   HALTED: imem_rd=0, instruction=NOP_INST, inst_stall=0, pc frozen; exit only via rst.
//  Outputs combinational from state/pc/buf/imem inputs; at most one read outstanding.
// TESTING
//  1 Reset then 4 single-cycle hits at 0000..0006 -> instruction each cycle, pc 0008,
//    incremented_pc 0002,0004,0006,0008, inst_stall=0.
//  2 Hit with imem_done delayed 3 cycles -> inst_stall=1 and NOP_INST for 3 cycles,
//    imem_addr stable, then word presented, pc advances by 2.
//  3 stall_fetch high 2 cycles on hit at 0010 -> imem_rd=0 while buffered, same word
//    re-presented, pc stays 0010, advances to 0012 after release.
//  4 pc_redirect to 0040 during WAIT at 0020 -> DRAIN, returned data discarded, next
//    imem_addr=0040, no word from 0020 presented.
//  5 Redirect to 0041 -> inst_mis_align=1, imem_rd=0, NOP_INST until redirect to 0080.
//  6 halt_in with pc_redirect same cycle -> redirect taken; halt_in alone -> imem_rd=0
//    forever, pc frozen; rst mid-WAIT -> pc=RESET_PC, state FETCH.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bundle: EX/decode control in, instruction-memory handshake, IF/ID fetch packet out.
// master = fetch stage, slave = memory/pipeline environment.
interface fetch_if;
    logic        pc_redirect;
    logic [15:0] redirect_pc;
    logic        stall_fetch;
    logic        halt_in;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic [15:0] instruction;
    logic [15:0] incremented_pc;
    logic        inst_stall;
    logic        inst_mis_align;

    modport master (
        input  pc_redirect, redirect_pc, stall_fetch, halt_in, imem_rdata, imem_done,
        output imem_rd, imem_addr, instruction, incremented_pc, inst_stall, inst_mis_align
    );
    modport slave (
        output pc_redirect, redirect_pc, stall_fetch, halt_in, imem_rdata, imem_done,
        input  imem_rd, imem_addr, instruction, incremented_pc, inst_stall, inst_mis_align
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs the imem read handshake, buffers a word across decode
// stalls and drains an in-flight read before honouring a redirect or halt.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  fif
);
    typedef enum logic [1:0] {FETCH, WAIT, DRAIN, HALTED} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] buf_word;
    logic        buf_valid;
    logic [15:0] drain_pc;
    logic        drain_halt;

    assign pc_inc             = pc + 16'd2;
    assign fif.imem_addr      = pc;
    assign fif.incremented_pc = pc_inc;

    // A redirect or halt in FETCH suppresses the request so no read is left outstanding.
    always_comb begin
        fif.imem_rd        = 1'b0;
        fif.instruction    = NOP_INST;
        fif.inst_stall     = 1'b0;
        fif.inst_mis_align = 1'b0;
        case (state)
            FETCH: begin
                fif.inst_mis_align = pc[0];
                if (!fif.pc_redirect && !fif.halt_in && !pc[0]) begin
                    if (buf_valid) begin
                        fif.instruction = buf_word;
                    end else begin
                        fif.imem_rd = 1'b1;
                        if (fif.imem_done) fif.instruction = fif.imem_rdata;
                        else               fif.inst_stall  = 1'b1;
                    end
                end
            end
            WAIT: begin
                fif.imem_rd = 1'b1;
                if (!fif.pc_redirect && !fif.halt_in) begin
                    if (fif.imem_done) fif.instruction = fif.imem_rdata;
                    else               fif.inst_stall  = 1'b1;
                end
            end
            DRAIN: begin
                fif.imem_rd    = 1'b1;
                fif.inst_stall = !fif.pc_redirect;
            end
            default: ;
        endcase
        if (rst) begin
            fif.imem_rd        = 1'b0;
            fif.instruction    = NOP_INST;
            fif.inst_stall     = 1'b0;
            fif.inst_mis_align = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            buf_word   <= NOP_INST;
            buf_valid  <= 1'b0;
            drain_pc   <= RESET_PC;
            drain_halt <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (fif.pc_redirect) begin
                        pc        <= fif.redirect_pc;
                        buf_valid <= 1'b0;
                    end else if (fif.halt_in) begin
                        state     <= HALTED;
                        buf_valid <= 1'b0;
                    end else if (!pc[0]) begin
                        if (buf_valid) begin
                            if (!fif.stall_fetch) begin
                                buf_valid <= 1'b0;
                                pc        <= pc_inc;
                            end
                        end else if (fif.imem_done) begin
                            if (fif.stall_fetch) begin
                                buf_word  <= fif.imem_rdata;
                                buf_valid <= 1'b1;
                            end else begin
                                pc <= pc_inc;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (fif.pc_redirect) begin
                        if (fif.imem_done) begin
                            pc    <= fif.redirect_pc;
                            state <= FETCH;
                        end else begin
                            drain_pc   <= fif.redirect_pc;
                            drain_halt <= 1'b0;
                            state      <= DRAIN;
                        end
                    end else if (fif.halt_in) begin
                        if (fif.imem_done) begin
                            state <= HALTED;
                        end else begin
                            drain_halt <= 1'b1;
                            state      <= DRAIN;
                        end
                    end else if (fif.imem_done) begin
                        state <= FETCH;
                        if (fif.stall_fetch) begin
                            buf_word  <= fif.imem_rdata;
                            buf_valid <= 1'b1;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                DRAIN: begin
                    // The newest redirect replaces whatever target (or halt) was pending.
                    if (fif.pc_redirect) begin
                        if (fif.imem_done) begin
                            pc    <= fif.redirect_pc;
                            state <= FETCH;
                        end else begin
                            drain_pc   <= fif.redirect_pc;
                            drain_halt <= 1'b0;
                        end
                    end else if (fif.imem_done) begin
                        if (drain_halt) begin
                            state <= HALTED;
                        end else begin
                            pc    <= drain_pc;
                            state <= FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, a halt-during-read sequence, then random
// traffic against a transaction-level model with a variable-latency memory.
module tb_fetch_stage;
    localparam logic [15:0] N = 16'h0800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if fif();
    fetch_stage #(.RESET_PC(16'h0000), .NOP_INST(N)) dut (.clk(clk), .rst(rst), .fif(fif));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        r, redir;
        logic [15:0] rpc;
        logic        stall, halt, done;
        logic [15:0] rdata;
        logic        e_rd;
        logic [15:0] e_addr, e_instr, e_inc;
        logic        e_st, e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic redir, logic [15:0] rpc, logic stall, logic halt,
                                logic done, logic [15:0] rdata, logic e_rd, logic [15:0] e_addr,
                                logic [15:0] e_instr, logic [15:0] e_inc, logic e_st, logic e_mis);
        vec_t v;
        v.r = r; v.redir = redir; v.rpc = rpc; v.stall = stall; v.halt = halt;
        v.done = done; v.rdata = rdata; v.e_rd = e_rd; v.e_addr = e_addr;
        v.e_instr = e_instr; v.e_inc = e_inc; v.e_st = e_st; v.e_mis = e_mis;
        return v;
    endfunction

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic drive(input logic r, input logic redir, input logic [15:0] rpc, input logic stall,
                         input logic halt, input logic done, input logic [15:0] rdata);
        @(negedge clk);
        rst = r;
        fif.pc_redirect = redir;
        fif.redirect_pc = rpc;
        fif.stall_fetch = stall;
        fif.halt_in     = halt;
        fif.imem_done   = done;
        fif.imem_rdata  = rdata;
        #1;
    endtask

    task automatic check(input string nm, input logic e_rd, input logic [15:0] e_addr,
                         input logic [15:0] e_instr, input logic [15:0] e_inc,
                         input logic e_st, input logic e_mis);
        total++;
        if ({fif.imem_rd, fif.imem_addr, fif.instruction, fif.incremented_pc, fif.inst_stall,
             fif.inst_mis_align} !== {e_rd, e_addr, e_instr, e_inc, e_st, e_mis}) begin
            bad++;
            $display("FAIL %s: got rd=%b addr=%h instr=%h inc=%h stall=%b mis=%b want rd=%b addr=%h instr=%h inc=%h stall=%b mis=%b",
                     nm, fif.imem_rd, fif.imem_addr, fif.instruction, fif.incremented_pc,
                     fif.inst_stall, fif.inst_mis_align, e_rd, e_addr, e_instr, e_inc, e_st, e_mis);
        end
    endtask

    // Reference model: tracks the architectural PC, an optional held word, and whether a
    // memory read is in flight and whether its data is wanted.
    logic [15:0] m_pc, m_buf, m_tgt;
    bit m_has_buf, m_busy, m_discard, m_halt_after, m_halted;
    int lat, cnt;

    task automatic model_reset();
        m_pc = 16'h0000; m_buf = N; m_tgt = 16'h0000;
        m_has_buf = 0; m_busy = 0; m_discard = 0; m_halt_after = 0; m_halted = 0;
        cnt = 0; lat = $urandom_range(0, 3);
    endtask

    initial begin
        fif.pc_redirect = 1'b0; fif.redirect_pc = 16'h0; fif.stall_fetch = 1'b0;
        fif.halt_in = 1'b0; fif.imem_done = 1'b0; fif.imem_rdata = 16'h0;

        // rst redir rpc stall halt done rdata | rd addr instr inc stall mis
        vecs.push_back(mk(1,0,16'h0000,0,0,0,16'h0000, 0,16'h0000,N,16'h0002,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'h1111, 1,16'h0000,16'h1111,16'h0002,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'h2222, 1,16'h0002,16'h2222,16'h0004,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'h3333, 1,16'h0004,16'h3333,16'h0006,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'h4444, 1,16'h0006,16'h4444,16'h0008,0,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,16'h0000,0,0,0,16'hDEAD, 1,16'h0008,N,16'h000A,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'h5555, 1,16'h0008,16'h5555,16'h000A,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'h6666, 1,16'h000A,16'h6666,16'h000C,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'h7777, 1,16'h000C,16'h7777,16'h000E,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'h8888, 1,16'h000E,16'h8888,16'h0010,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,1,16'h9999, 1,16'h0010,16'h9999,16'h0012,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0,16'hBEEF, 0,16'h0010,16'h9999,16'h0012,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,16'hBEEF, 0,16'h0010,16'h9999,16'h0012,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'hAAAA, 1,16'h0012,16'hAAAA,16'h0014,0,0));
        vecs.push_back(mk(0,1,16'h0020,0,0,0,16'h0000, 0,16'h0014,N,16'h0016,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,16'h0000, 1,16'h0020,N,16'h0022,1,0));
        vecs.push_back(mk(0,1,16'h0040,0,0,0,16'h0000, 1,16'h0020,N,16'h0022,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,16'h0000, 1,16'h0020,N,16'h0022,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'hBBBB, 1,16'h0020,N,16'h0022,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'hCCCC, 1,16'h0040,16'hCCCC,16'h0042,0,0));
        vecs.push_back(mk(0,1,16'h0041,0,0,0,16'h0000, 0,16'h0042,N,16'h0044,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,16'h0000, 0,16'h0041,N,16'h0043,0,1));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,16'h0000, 0,16'h0041,N,16'h0043,0,1));
        vecs.push_back(mk(0,1,16'h0080,0,0,0,16'h0000, 0,16'h0041,N,16'h0043,0,1));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'hDDDD, 1,16'h0080,16'hDDDD,16'h0082,0,0));
        vecs.push_back(mk(0,1,16'hFFFE,0,0,0,16'h0000, 0,16'h0082,N,16'h0084,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'hF00D, 1,16'hFFFE,16'hF00D,16'h0000,0,0));
        vecs.push_back(mk(0,1,16'h0100,0,1,0,16'h0000, 0,16'h0000,N,16'h0002,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'hEEEE, 1,16'h0100,16'hEEEE,16'h0102,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,0,16'h0000, 0,16'h0102,N,16'h0104,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'h7777, 0,16'h0102,N,16'h0104,0,0));
        vecs.push_back(mk(0,1,16'h0200,0,0,0,16'h0000, 0,16'h0102,N,16'h0104,0,0));
        vecs.push_back(mk(1,0,16'h0000,0,0,0,16'h0000, 0,16'h0000,N,16'h0002,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,16'h0000, 1,16'h0000,N,16'h0002,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,16'h0000, 1,16'h0000,N,16'h0002,1,0));
        vecs.push_back(mk(1,0,16'h0000,0,0,0,16'h0000, 0,16'h0000,N,16'h0002,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,16'h1234, 1,16'h0000,16'h1234,16'h0002,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].redir, vecs[i].rpc, vecs[i].stall, vecs[i].halt,
                  vecs[i].done, vecs[i].rdata);
            check($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_instr,
                  vecs[i].e_inc, vecs[i].e_st, vecs[i].e_mis);
        end

        // Halt while a read is in flight: read must complete (drained) before fetch stops.
        drive(0,0,16'h0,0,0,0,16'h0);     check("hw_wait",   1,16'h0002,N,16'h0004,1,0);
        drive(0,0,16'h0,0,1,0,16'h0);     check("hw_halt",   1,16'h0002,N,16'h0004,0,0);
        drive(0,0,16'h0,0,0,0,16'h0);     check("hw_drain",  1,16'h0002,N,16'h0004,1,0);
        drive(0,0,16'h0,0,0,1,16'h4321);  check("hw_done",   1,16'h0002,N,16'h0004,1,0);
        drive(0,0,16'h0,0,0,1,16'h4321);  check("hw_halted", 0,16'h0002,N,16'h0004,0,0);

        // Random traffic against the model.
        drive(1,0,16'h0,0,0,0,16'h0);
        check("rnd_rst", 0,16'h0000,N,16'h0002,0,0);
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            logic r, redir, stall, halt, done, e_rd, e_st, e_mis;
            logic [15:0] rpc, rdata, e_instr, e_inc;
            r     = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 7) == 0);
            redir = $urandom_range(0, 99) < 8;
            rpc   = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 15) != 0) rpc[0] = 1'b0;
            if ($urandom_range(0, 31) == 0) rpc = 16'hFFFE;
            halt  = $urandom_range(0, 99) < 2;
            stall = $urandom_range(0, 3) == 0;
            if (r) begin
                drive(1, redir, rpc, stall, halt, 1'b0, 16'h0);
                check("rnd_rst", 0,16'h0000,N,16'h0002,0,0);
                model_reset();
                continue;
            end
            e_rd = m_halted ? 1'b0 : (m_busy || m_discard) ? 1'b1
                 : (redir || halt || m_pc[0] || m_has_buf) ? 1'b0 : 1'b1;
            done  = e_rd && (cnt >= lat);
            rdata = done ? mem_word(m_pc) : 16'($urandom_range(0, 65535));
            drive(0, redir, rpc, stall, halt, done, rdata);
            e_instr = N; e_st = 1'b0; e_mis = 1'b0; e_inc = m_pc + 16'd2;
            if (m_halted) begin
            end else if (m_discard) begin
                e_st = !redir;
                if (redir) begin
                    if (done) begin m_pc = rpc; m_discard = 0; end
                    else begin m_tgt = rpc; m_halt_after = 0; end
                end else if (done) begin
                    m_discard = 0;
                    if (m_halt_after) m_halted = 1; else m_pc = m_tgt;
                end
            end else if (m_busy) begin
                if (redir) begin
                    m_busy = 0;
                    if (done) m_pc = rpc;
                    else begin m_discard = 1; m_tgt = rpc; m_halt_after = 0; end
                end else if (halt) begin
                    m_busy = 0;
                    if (done) m_halted = 1;
                    else begin m_discard = 1; m_halt_after = 1; end
                end else if (done) begin
                    m_busy = 0; e_instr = rdata;
                    if (stall) begin m_has_buf = 1; m_buf = rdata; end
                    else m_pc = m_pc + 16'd2;
                end else e_st = 1'b1;
            end else begin
                e_mis = m_pc[0];
                if (redir) begin m_pc = rpc; m_has_buf = 0; end
                else if (halt) begin m_halted = 1; m_has_buf = 0; end
                else if (m_pc[0]) begin end
                else if (m_has_buf) begin
                    e_instr = m_buf;
                    if (!stall) begin m_has_buf = 0; m_pc = m_pc + 16'd2; end
                end else if (done) begin
                    e_instr = rdata;
                    if (stall) begin m_has_buf = 1; m_buf = rdata; end
                    else m_pc = m_pc + 16'd2;
                end else begin
                    e_st = 1'b1; m_busy = 1;
                end
            end
            check($sformatf("rnd%0d", c), e_rd, fif.imem_addr === fif.imem_addr ? e_inc - 16'd2 : 16'hx,
                  e_instr, e_inc, e_st, e_mis);
            if (e_rd && !done) cnt++;
            else if (done) begin cnt = 0; lat = $urandom_range(0, 3); end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
